// File: rtl/uart_rx32_if.sv
// rtl/uart_rx32_if.sv - serial line and word-output bundle of the 32-bit UART receiver
//
// Purpose: groups the receiver's line input and its word/status outputs.
// Signals:
//   rx         serial line into the receiver, idles high
//   data_out   last good 32-bit word received
//   valid      one-cycle strobe, data_out updated in the same cycle
//   frame_err  one-cycle strobe when the stop bit was sampled low
//   busy       receiver is not idle
// Modports: master = line driver / word consumer, slave = receiver.
interface uart_rx32_if;
  logic        rx;
  logic [31:0] data_out;
  logic        valid;
  logic        frame_err;
  logic        busy;

  modport master (output rx, input data_out, input valid, input frame_err, input busy);
  modport slave  (input rx, output data_out, output valid, output frame_err, output busy);
endinterface

// File: rtl/uart_rx32.sv
// rtl/uart_rx32.sv - 34-bit frame UART receiver (start, 32 data LSB first, stop)
//
// Purpose: receives one 32-bit word per frame from the host/debug link and
// presents it with a one-cycle valid strobe. A low stop bit gives a one-cycle
// frame_err strobe and the receiver then waits for the line to return high.
// Ports:
//   clk   system clock, all logic on posedge
//   rst   synchronous active-high reset, priority over everything
//   bus   uart_rx32_if.slave: rx in; data_out, valid, frame_err, busy out
// Parameters:
//   CLK_FREQ  clock frequency in Hz
//   BAUD      line bit rate; BAUD_DIV = CLK_FREQ/BAUD, HALF = BAUD_DIV/2
module uart_rx32 #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst,
  uart_rx32_if.slave  bus
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
  localparam int unsigned HALF     = BAUD_DIV / 2;
  localparam logic [31:0] DIV_M1   = 32'(BAUD_DIV - 1);
  localparam logic [31:0] HALF_M1  = 32'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t      state, state_n;
  logic        rx_meta, rx_s;
  logic [31:0] cnt, cnt_n;
  logic [5:0]  bit_idx, bit_idx_n;
  logic [31:0] shift, shift_n;
  logic [31:0] data_q, data_n;
  logic        valid_q, valid_n;
  logic        ferr_q, ferr_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      // synchronizer resets to the idle line level so reset alone never looks like a start edge
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      ferr_q  <= ferr_n;
    end
  end

  always_comb begin
    state_n   = state;
    // baud counter free-runs outside IDLE; each sample point and state change clears it
    cnt_n     = (state == S_IDLE) ? 32'd0 : cnt + 32'd1;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    data_n    = data_q;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;

    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_n = S_START;
        end
      end
      S_START: begin
        // re-check the line at mid start bit; a short low glitch returns silently to IDLE
        if (cnt == HALF_M1) begin
          cnt_n = 32'd0;
          if (!rx_s) begin
            state_n   = S_DATA;
            bit_idx_n = 6'd0;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt == DIV_M1) begin
          cnt_n     = 32'd0;
          shift_n   = {rx_s, shift[31:1]};
          bit_idx_n = bit_idx + 6'd1;
          if (bit_idx == 6'd31) begin
            state_n = S_STOP;
          end
        end
      end
      S_STOP: begin
        // leave at mid stop bit so a start edge right after a single stop bit is caught
        if (cnt == DIV_M1) begin
          cnt_n = 32'd0;
          if (rx_s) begin
            data_n  = shift;
            valid_n = 1'b1;
            state_n = S_IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // a line held low after a bad stop bit must not re-trigger a frame
        if (rx_s) begin
          cnt_n   = 32'd0;
          state_n = S_IDLE;
        end
      end
      default: begin
        cnt_n   = 32'd0;
        state_n = S_IDLE;
      end
    endcase
  end

  assign bus.data_out  = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx32.sv
// tb/tb_uart_rx32.sv - scoreboard testbench for uart_rx32
module tb_uart_rx32;

  logic clk;
  logic rst;
  int   cyc;

  uart_rx32_if ifa ();
  uart_rx32_if ifb ();

  uart_rx32 #(.CLK_FREQ(16), .BAUD(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  uart_rx32 #(.CLK_FREQ(100_000_000), .BAUD(115200)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  typedef struct packed {
    logic        is_err;
    logic [31:0] data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_vec;
  int   n_err;
  int   evt_a;
  int   evt_b;
  int   vcyc_a;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) ifa.rx = v;
    else          ifb.rx = v;
  endtask

  // line is left at the stop-bit level when the frame ends
  task automatic send(input int sel, input logic [31:0] w, input int per, input logic stop_bit);
    logic [33:0] f;
    f = {stop_bit, w, 1'b0};
    for (int i = 0; i < 34; i++) begin
      set_rx(sel, f[i]);
      wait_cycles(per);
    end
  endtask

  task automatic wait_drain(input int sel, input int budget);
    int k;
    k = 0;
    while (((sel == 0) ? qa.size() : qb.size()) != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("drain", 32'((sel == 0) ? qa.size() : qb.size()), 32'd0);
  endtask

  task automatic monitor(input int sel);
    logic        v, fe;
    logic [31:0] d;
    exp_t        e;
    forever begin
      @(negedge clk);
      v  = (sel == 0) ? ifa.valid     : ifb.valid;
      fe = (sel == 0) ? ifa.frame_err : ifb.frame_err;
      d  = (sel == 0) ? ifa.data_out  : ifb.data_out;
      if (v || fe) begin
        if (sel == 0) begin
          evt_a++;
          if (v) vcyc_a = cyc;
        end else begin
          evt_b++;
        end
        chk("valid_and_frame_err", {31'd0, v & fe}, 32'd0);
        n_vec++;
        if (((sel == 0) ? qa.size() : qb.size()) == 0) begin
          n_err++;
          $display("FAIL unexpected_event dut%0d: valid=%b frame_err=%b data=%h, none expected", sel, v, fe, d);
        end else begin
          e = (sel == 0) ? qa.pop_front() : qb.pop_front();
          chk("event_kind_is_err", {31'd0, fe}, {31'd0, e.is_err});
          chk("data_out", d, e.data);
        end
      end
    end
  endtask

  initial begin
    logic [33:0] f;
    int          t0;
    int          ev0;
    logic [31:0] w;

    clk    = 1'b0;
    rst    = 1'b1;
    ifa.rx = 1'b1;
    ifb.rx = 1'b1;
    n_vec  = 0;
    n_err  = 0;
    evt_a  = 0;
    evt_b  = 0;
    vcyc_a = 0;
    fork
      monitor(0);
      monitor(1);
    join_none

    // reset state
    wait_cycles(2);
    chk("rst_data_out",  ifa.data_out, 32'd0);
    chk("rst_valid",     {31'd0, ifa.valid}, 32'd0);
    chk("rst_frame_err", {31'd0, ifa.frame_err}, 32'd0);
    chk("rst_busy",      {31'd0, ifa.busy}, 32'd0);
    chk("rst_busy_b",    {31'd0, ifb.busy}, 32'd0);
    rst = 1'b0;
    wait_cycles(4);

    // 1: single frame, with latency 2 + HALF + 33*BAUD_DIV = 538 +/- 1
    qa.push_back('{is_err: 1'b0, data: 32'hDEADBEEF});
    t0 = cyc;
    send(0, 32'hDEADBEEF, 16, 1'b1);
    wait_drain(0, 100);
    n_vec++;
    if (vcyc_a - t0 < 537 || vcyc_a - t0 > 539) begin
      n_err++;
      $display("FAIL latency: got %0d cycles want 538 +/- 1", vcyc_a - t0);
    end
    wait_cycles(4);
    chk("t1_busy_idle", {31'd0, ifa.busy}, 32'd0);

    // 2: back-to-back frames with a single stop bit
    qa.push_back('{is_err: 1'b0, data: 32'h00000000});
    qa.push_back('{is_err: 1'b0, data: 32'hFFFFFFFF});
    send(0, 32'h00000000, 16, 1'b1);
    send(0, 32'hFFFFFFFF, 16, 1'b1);
    wait_drain(0, 100);
    wait_cycles(10);

    // 3: short low glitch rejected at mid start bit
    ev0 = evt_a;
    ifa.rx = 1'b0;
    wait_cycles(4);
    ifa.rx = 1'b1;
    chk("t3_busy_in_start", {31'd0, ifa.busy}, 32'd1);
    wait_cycles(20);
    chk("t3_busy_idle", {31'd0, ifa.busy}, 32'd0);
    chk("t3_no_event", 32'(evt_a - ev0), 32'd0);

    // 4: bad stop bit, line held low, then recovery
    ev0 = evt_a;
    qa.push_back('{is_err: 1'b1, data: 32'hFFFFFFFF});
    send(0, 32'h12345678, 16, 1'b0);
    wait_cycles(40);
    chk("t4_busy_in_break", {31'd0, ifa.busy}, 32'd1);
    chk("t4_single_event", 32'(evt_a - ev0), 32'd1);
    ifa.rx = 1'b1;
    wait_cycles(6);
    chk("t4_busy_idle", {31'd0, ifa.busy}, 32'd0);
    chk("t4_data_held", ifa.data_out, 32'hFFFFFFFF);
    wait_drain(0, 10);
    qa.push_back('{is_err: 1'b0, data: 32'hCAFEF00D});
    send(0, 32'hCAFEF00D, 16, 1'b1);
    wait_drain(0, 100);
    wait_cycles(10);

    // 5: reset at mid data bit 10, then a clean frame
    f = {1'b1, 32'h0F0F0F0F, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ifa.rx = f[i];
      wait_cycles(16);
    end
    ifa.rx = f[11];
    wait_cycles(8);
    rst = 1'b1;
    wait_cycles(1);
    chk("t5_data_out",  ifa.data_out, 32'd0);
    chk("t5_valid",     {31'd0, ifa.valid}, 32'd0);
    chk("t5_frame_err", {31'd0, ifa.frame_err}, 32'd0);
    chk("t5_busy",      {31'd0, ifa.busy}, 32'd0);
    rst = 1'b0;
    ifa.rx = 1'b1;
    wait_cycles(20);
    qa.push_back('{is_err: 1'b0, data: 32'hA5A5A5A5});
    send(0, 32'hA5A5A5A5, 16, 1'b1);
    wait_drain(0, 100);

    // 6: real baud rate (BAUD_DIV=868), transmitter 1% fast then 1% slow;
    // a 34-bit frame tolerates only about 1.4% total clock mismatch
    wait_cycles(20);
    w = $urandom;
    qb.push_back('{is_err: 1'b0, data: w});
    send(1, w, 859, 1'b1);
    w = $urandom;
    qb.push_back('{is_err: 1'b0, data: w});
    send(1, w, 877, 1'b1);
    wait_drain(1, 2000);
    chk("t6_event_count", 32'(evt_b), 32'd2);
    chk("t6_qa_untouched", 32'(qa.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
